multicycle_control: RTL

Multi-cycle sequencing controller for the MIPS core. It replaces per-instruction single-cycle decode with a Moore FSM that steps one shared ALU, one unified instruction/data memory and the register file through fetch, decode, execute, memory and write-back. It sits between the instruction register's opcode field and the datapath's mux selects and write enables. It stalls on a memory ready handshake.

---
 rtl/mips_ctrl_pkg.sv | 62 ++++++
 rtl/mc_output_decode.sv | 78 +++++++
 rtl/multicycle_control.sv | 95 +++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared state, opcode, ALU and select encodings for the multi-cycle controller
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        RST, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE,
        R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, ILLEGAL
    } stateT;

    localparam logic [5:0] R_TYPE = 6'h00;
    localparam logic [5:0] J      = 6'h02;
    localparam logic [5:0] BEQ    = 6'h04;
    localparam logic [5:0] BNE    = 6'h05;
    localparam logic [5:0] ADDI   = 6'h08;
    localparam logic [5:0] ORI    = 6'h0d;
    localparam logic [5:0] LW     = 6'h23;
    localparam logic [5:0] SW     = 6'h2b;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_ADDI  = 3'b100;
    localparam logic [2:0] ALU_ORI   = 3'b101;
    localparam logic [2:0] ALU_RTYPE = 3'b111;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCondEq;
        logic       pcWriteCondNe;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       memToReg;
        logic       regDst;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [2:0] aluOp;
        logic [1:0] pcSource;
        logic       illegalOp;
    } ctrlT;

    function automatic stateT decodeNext(input logic [5:0] op);
        case (op)
            R_TYPE:    return R_EXEC;
            ADDI, ORI: return I_EXEC;
            LW, SW:    return MEM_ADDR;
            BEQ, BNE:  return BRANCH;
            J:         return JUMP;
            default:   return ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/mc_output_decode.sv
// mc_output_decode: maps controller state, latched opcode and memory ready to the datapath control vector
module mc_output_decode
    import mips_ctrl_pkg::*;
(
    input  stateT      state,
    input  logic [5:0] op,
    input  logic       memReady,
    output ctrlT       ctrl
);

    // Moore decode per state; only the FETCH IR/PC loads follow memReady
    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.memRead = 1'b1;
                ctrl.irWrite = memReady;
                ctrl.pcWrite = memReady;
                ctrl.aluSrcB = SRCB_FOUR;
                ctrl.aluOp   = ALU_ADD;
            end
            DECODE: begin
                ctrl.aluSrcB = SRCB_IMMSH2;
                ctrl.aluOp   = ALU_ADD;
            end
            MEM_ADDR: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_IMM;
                ctrl.aluOp   = ALU_ADD;
            end
            MEM_READ: begin
                ctrl.memRead = 1'b1;
                ctrl.iorD    = 1'b1;
            end
            MEM_WB: begin
                ctrl.memToReg = 1'b1;
                ctrl.regWrite = 1'b1;
            end
            MEM_WRITE: begin
                ctrl.memWrite = 1'b1;
                ctrl.iorD     = 1'b1;
            end
            R_EXEC: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluOp   = ALU_RTYPE;
            end
            R_WB: begin
                ctrl.regDst   = 1'b1;
                ctrl.regWrite = 1'b1;
                ctrl.aluOp    = ALU_RTYPE;
            end
            I_EXEC: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_IMM;
                ctrl.aluOp   = (op == ORI) ? ALU_ORI : ALU_ADDI;
            end
            I_WB: begin
                ctrl.regWrite = 1'b1;
                ctrl.aluOp    = (op == ORI) ? ALU_ORI : ALU_ADDI;
            end
            BRANCH: begin
                ctrl.aluSrcA       = 1'b1;
                ctrl.aluSrcB       = SRCB_RT;
                ctrl.aluOp         = ALU_SUB;
                ctrl.pcSource      = PCSRC_ALUOUT;
                ctrl.pcWriteCondEq = (op == BEQ);
                ctrl.pcWriteCondNe = (op == BNE);
            end
            JUMP: begin
                ctrl.pcSource = PCSRC_JUMP;
                ctrl.pcWrite  = 1'b1;
            end
            ILLEGAL: ctrl.illegalOp = 1'b1;
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore sequencing FSM for the multi-cycle MIPS datapath with a retired-instruction counter
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           OP,
    input  logic                 mem_ready,
    output logic                 PCWrite,
    output logic                 PCWriteCondEQ,
    output logic                 PCWriteCondNE,
    output logic                 IorD,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 MemtoReg,
    output logic                 RegDst,
    output logic                 RegWrite,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [2:0]           ALUOp,
    output logic [1:0]           PCSource,
    output logic                 illegal_op,
    output logic [CNT_WIDTH-1:0] retired
);

    localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    stateT      state;
    stateT      nextState;
    logic [5:0] opReg;
    logic       retire;
    ctrlT       ctrl;
    ctrlT       ctrlOut;

    // Next-state selection; terminal states and unknown encodings fall back to FETCH
    always_comb begin
        nextState = FETCH;
        case (state)
            RST:       nextState = FETCH;
            FETCH:     nextState = mem_ready ? DECODE : FETCH;
            DECODE:    nextState = decodeNext(OP);
            MEM_ADDR:  nextState = (OP == LW) ? MEM_READ : MEM_WRITE;
            MEM_READ:  nextState = mem_ready ? MEM_WB : MEM_READ;
            MEM_WRITE: nextState = mem_ready ? FETCH : MEM_WRITE;
            R_EXEC:    nextState = R_WB;
            I_EXEC:    nextState = I_WB;
            default:   nextState = FETCH;
        endcase
    end

    assign retire = (state inside {MEM_WB, R_WB, I_WB, BRANCH, JUMP}) || (state == MEM_WRITE && mem_ready);

    // State register, opcode latch (keeps OP out of the output path) and retired counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RST;
            opReg   <= '0;
            retired <= '0;
        end else begin
            state <= nextState;
            if (state == DECODE) opReg <= OP;
            if (retire) retired <= retired + ONE;
        end
    end

    mc_output_decode uDecode (
        .state    (state),
        .op       (opReg),
        .memReady (mem_ready),
        .ctrl     (ctrl)
    );

    // A reset cycle must never issue a strobe, even if the state register holds a write state
    assign ctrlOut = reset ? '0 : ctrl;

    assign PCWrite       = ctrlOut.pcWrite;
    assign PCWriteCondEQ = ctrlOut.pcWriteCondEq;
    assign PCWriteCondNE = ctrlOut.pcWriteCondNe;
    assign IorD          = ctrlOut.iorD;
    assign MemRead       = ctrlOut.memRead;
    assign MemWrite      = ctrlOut.memWrite;
    assign IRWrite       = ctrlOut.irWrite;
    assign MemtoReg      = ctrlOut.memToReg;
    assign RegDst        = ctrlOut.regDst;
    assign RegWrite      = ctrlOut.regWrite;
    assign ALUSrcA       = ctrlOut.aluSrcA;
    assign ALUSrcB       = ctrlOut.aluSrcB;
    assign ALUOp         = ctrlOut.aluOp;
    assign PCSource      = ctrlOut.pcSource;
    assign illegal_op    = ctrlOut.illegalOp;

endmodule
